// File: rtl/mem_arbiter.sv
// Merges the CPU fetch port and data port onto one registered physical memory port.
// Data wins ties, but a fetch is forced through after STARVE_LIMIT back-to-back data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic        imem_read,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [3:0]  dmem_byte_enable,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] phys_addr,
  output logic [31:0] phys_wdata,
  output logic        phys_read,
  output logic        phys_write,
  output logic [3:0]  phys_byte_enable,
  input  logic [31:0] phys_rdata,
  input  logic        phys_resp
);

  // state  | meaning
  // IDLE   | no transaction; arbitrate on this edge
  // BUSY_I | fetch on the physical port, waiting for phys_resp
  // BUSY_D | load/store on the physical port, waiting for phys_resp
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_starve_cnt;
  logic [31:0] r_imem_rdata;
  logic [31:0] r_dmem_rdata;
  logic [31:0] r_phys_addr;
  logic [31:0] r_phys_wdata;
  logic        r_phys_read;
  logic        r_phys_write;
  logic [3:0]  r_phys_be;
  logic        w_dreq;
  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_done;

  assign w_dreq = dmem_read | dmem_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_grant_d  = 1'b0;
    w_grant_i  = 1'b0;
    w_done     = 1'b0;
    imem_resp  = 1'b0;
    dmem_resp  = 1'b0;
    imem_rdata = r_imem_rdata;
    dmem_rdata = r_dmem_rdata;
    case (r_state)
      IDLE: begin
        if (w_dreq && ((r_starve_cnt < LIMIT) || !imem_read)) begin
          w_grant_d = 1'b1;
          w_next    = BUSY_D;
        end else if (imem_read) begin
          w_grant_i = 1'b1;
          w_next    = BUSY_I;
        end
      end
      BUSY_I: begin
        if (phys_resp) begin
          w_done = 1'b1;
          w_next = IDLE;
          // An abandoned request still finishes on the bus but is not acknowledged.
          if (imem_read) begin
            imem_resp  = 1'b1;
            imem_rdata = phys_rdata;
          end
        end
      end
      BUSY_D: begin
        if (phys_resp) begin
          w_done = 1'b1;
          w_next = IDLE;
          if (w_dreq) begin
            dmem_resp  = 1'b1;
            dmem_rdata = phys_rdata;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phys_addr  <= '0;
      r_phys_wdata <= '0;
      r_phys_read  <= 1'b0;
      r_phys_write <= 1'b0;
      r_phys_be    <= '0;
      r_imem_rdata <= '0;
      r_dmem_rdata <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_grant_d) begin
        r_phys_addr  <= dmem_addr;
        r_phys_wdata <= dmem_wdata;
        r_phys_be    <= dmem_byte_enable;
        // Read and write together is illegal; the write takes precedence.
        r_phys_read  <= dmem_read & ~dmem_write;
        r_phys_write <= dmem_write;
      end else if (w_grant_i) begin
        r_phys_addr  <= {imem_addr[31:2], 2'b00};
        r_phys_wdata <= '0;
        r_phys_be    <= 4'hF;
        r_phys_read  <= 1'b1;
        r_phys_write <= 1'b0;
      end else if (w_done) begin
        r_phys_read  <= 1'b0;
        r_phys_write <= 1'b0;
      end

      if (imem_resp) r_imem_rdata <= phys_rdata;
      if (dmem_resp) r_dmem_rdata <= phys_rdata;

      if (r_state == IDLE) begin
        if (!imem_read || w_grant_i) begin
          r_starve_cnt <= '0;
        end else if (w_grant_d && (r_starve_cnt != 4'hF)) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end
    end
  end

  assign phys_addr        = r_phys_addr;
  assign phys_wdata       = r_phys_wdata;
  assign phys_read        = r_phys_read;
  assign phys_write       = r_phys_write;
  assign phys_byte_enable = r_phys_be;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, tie, starvation, store, alignment,
// abandoned request, stray phys_resp and reset during a transaction.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] phys_addr;
  logic [31:0] phys_wdata;
  logic        phys_read;
  logic        phys_write;
  logic [3:0]  phys_byte_enable;
  logic [31:0] phys_rdata;
  logic        phys_resp;

  int n_tests = 0;
  int n_fail  = 0;
  int k;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_read(imem_read),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .phys_addr(phys_addr), .phys_wdata(phys_wdata),
    .phys_read(phys_read), .phys_write(phys_write),
    .phys_byte_enable(phys_byte_enable),
    .phys_rdata(phys_rdata), .phys_resp(phys_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completes the current physical transaction and checks the response pulses.
  task automatic serve(input logic [31:0] rd, input logic exp_i, input logic exp_d, input string tag);
    phys_rdata = rd;
    phys_resp  = 1'b1;
    #1;
    chk({tag, "_iresp"}, 32'(imem_resp), 32'(exp_i));
    chk({tag, "_dresp"}, 32'(dmem_resp), 32'(exp_d));
    if (exp_i) chk({tag, "_irdata"}, imem_rdata, rd);
    if (exp_d) chk({tag, "_drdata"}, dmem_rdata, rd);
    tick();
    phys_resp  = 1'b0;
    phys_rdata = '0;
    chk({tag, "_strobe_drop"}, 32'({phys_read, phys_write}), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    imem_addr = '0; imem_read = 1'b0;
    dmem_addr = '0; dmem_wdata = '0; dmem_read = 1'b0; dmem_write = 1'b0;
    dmem_byte_enable = '0; phys_rdata = '0; phys_resp = 1'b0;

    tick();
    chk("rst_phys_read",  32'(phys_read), 32'd0);
    chk("rst_phys_write", 32'(phys_write), 32'd0);
    chk("rst_phys_addr",  phys_addr, 32'd0);
    chk("rst_resp",       32'({imem_resp, dmem_resp}), 32'd0);
    chk("rst_rdata",      imem_rdata | dmem_rdata, 32'd0);
    rst = 1'b1;
    tick();

    // Single fetch, response three cycles after the strobe rises
    imem_addr = 32'h60; imem_read = 1'b1;
    tick();
    chk("fetch_phys_read", 32'(phys_read), 32'd1);
    chk("fetch_phys_addr", phys_addr, 32'h60);
    chk("fetch_phys_be",   32'(phys_byte_enable), 32'hF);
    tick();
    tick();
    chk("fetch_hold_read", 32'(phys_read), 32'd1);
    chk("fetch_no_early_resp", 32'(imem_resp), 32'd0);
    serve(32'h13, 1'b1, 1'b0, "fetch");
    imem_read = 1'b0;
    chk("fetch_rdata_held", imem_rdata, 32'h13);

    // Tie: data first, fetch in the following IDLE
    imem_addr = 32'h80; imem_read = 1'b1;
    dmem_addr = 32'h200; dmem_read = 1'b1;
    tick();
    chk("tie_first_addr", phys_addr, 32'h200);
    serve(32'h55, 1'b0, 1'b1, "tie_d");
    dmem_read = 1'b0;
    tick();
    chk("tie_second_addr", phys_addr, 32'h80);
    chk("tie_second_read", 32'(phys_read), 32'd1);
    serve(32'h66, 1'b1, 1'b0, "tie_i");
    imem_read = 1'b0;

    // Starvation: grant order D D D D I D D
    imem_addr = 32'h40; imem_read = 1'b1;
    k = 0;
    dmem_addr = 32'h1000; dmem_read = 1'b1;
    for (int g = 0; g < 7; g++) begin
      tick();
      if (g == 4) begin
        chk("starve_fetch_addr", phys_addr, 32'h40);
        serve(32'hA0, 1'b1, 1'b0, "starve_i");
        imem_read = 1'b0;
      end else begin
        chk("starve_data_addr", phys_addr, 32'h1000 + 32'(4 * k));
        serve(32'hB0 + 32'(k), 1'b0, 1'b1, "starve_d");
        k++;
        dmem_addr = 32'h1000 + 32'(4 * k);
        if (k == 6) dmem_read = 1'b0;
      end
    end

    // Store passes through unmodified
    dmem_addr = 32'h104; dmem_wdata = 32'hDEADBEEF; dmem_byte_enable = 4'h3; dmem_write = 1'b1;
    tick();
    chk("store_addr",  phys_addr, 32'h104);
    chk("store_wdata", phys_wdata, 32'hDEADBEEF);
    chk("store_be",    32'(phys_byte_enable), 32'h3);
    chk("store_write", 32'(phys_write), 32'd1);
    chk("store_read",  32'(phys_read), 32'd0);
    serve(32'h0, 1'b0, 1'b1, "store");
    dmem_write = 1'b0;

    // Unaligned fetch is word-aligned with all lanes enabled
    imem_addr = 32'h63; imem_read = 1'b1;
    tick();
    chk("unal_addr", phys_addr, 32'h60);
    chk("unal_be",   32'(phys_byte_enable), 32'hF);
    serve(32'hC0, 1'b1, 1'b0, "unal");
    imem_read = 1'b0;

    // Fetch abandoned mid-transaction: no pulse, rdata unchanged
    imem_addr = 32'h20; imem_read = 1'b1;
    tick();
    chk("drop_read", 32'(phys_read), 32'd1);
    imem_read = 1'b0;
    serve(32'h77, 1'b0, 1'b0, "drop");
    chk("drop_rdata_kept", imem_rdata, 32'hC0);

    // Stray phys_resp while idle
    phys_resp = 1'b1; phys_rdata = 32'h99;
    #1;
    chk("idle_resp", 32'({imem_resp, dmem_resp}), 32'd0);
    tick();
    phys_resp = 1'b0;
    chk("idle_no_strobe", 32'({phys_read, phys_write}), 32'd0);

    // Read and write together act as a write
    dmem_addr = 32'h300; dmem_read = 1'b1; dmem_write = 1'b1; dmem_byte_enable = 4'hF;
    tick();
    chk("rw_write", 32'(phys_write), 32'd1);
    chk("rw_read",  32'(phys_read), 32'd0);
    serve(32'h1, 1'b0, 1'b1, "rw");
    dmem_read = 1'b0; dmem_write = 1'b0;

    // Reset during a store: strobe drops at once, late phys_resp ignored
    dmem_addr = 32'h400; dmem_write = 1'b1;
    tick();
    chk("rmid_write_before", 32'(phys_write), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rmid_write_dropped", 32'(phys_write), 32'd0);
    phys_resp = 1'b1;
    #1;
    chk("rmid_late_resp", 32'(dmem_resp), 32'd0);
    phys_resp = 1'b0;
    dmem_write = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rmid_idle", 32'({phys_read, phys_write}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
